// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one synchronous data-memory port between the CPU and a loader.
// Optional loader lock: define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_length,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_length,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRdCpu, StRdLdr} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;  // 1: loader was granted most recently
  logic   lock_active;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  // The lock only survives an idle cycle while the loader keeps ldr_lock high.
  assign lock_active = lock_q & ldr_lock;

  always_comb begin
    lock_d = lock_q;
    if (state_q == StIdle) begin
      lock_d = ldr_gnt ? ldr_lock : lock_active;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ldr_lock;
  assign lock_active = 1'b0;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (lock_active) begin
          ldr_gnt = ldr_req;
        end else if (cpu_req && ldr_req) begin
          cpu_gnt = last_q;
          ldr_gnt = ~last_q;
        end else begin
          cpu_gnt = cpu_req;
          ldr_gnt = ldr_req;
        end
        if (cpu_gnt) begin
          last_d  = 1'b0;
          state_d = cpu_we ? StIdle : StRdCpu;
        end else if (ldr_gnt) begin
          last_d  = 1'b1;
          state_d = ldr_we ? StIdle : StRdLdr;
        end
      end
      StRdCpu, StRdLdr: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign cpu_rvalid = (state_q == StRdCpu);
  assign ldr_rvalid = (state_q == StRdLdr);
  assign rdata      = mem_rdata;

  assign mem_en     = cpu_gnt | ldr_gnt;
  assign mem_we     = ldr_gnt ? ldr_we : (cpu_gnt & cpu_we);
  assign mem_addr   = ldr_gnt ? ldr_addr : cpu_addr;
  assign mem_wdata  = ldr_gnt ? ldr_wdata : cpu_wdata;
  assign mem_length = ldr_gnt ? 2'b10 : cpu_length;

  assign cpu_stall  = cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid;

endmodule
